// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high a..g,dp patterns; index = hex nibble (entry 0 is the LSB slot).
  localparam logic [15:0][7:0] HEX_PAT = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the scan controller: image update strobe, data and pending flag.
interface seg7_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  wr_en;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dp;
  logic [DIGITS-1:0]     wr_blank;
  logic                  upd_pend;

  modport master (output wr_en, wr_data, wr_dp, wr_blank, input  upd_pend);
  modport slave  (input  wr_en, wr_data, wr_dp, wr_blank, output upd_pend);
endinterface

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational hex nibble + dp to active-low segment pattern.
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  assign seg_o = ~(HEX_PAT[nibble_i] | {7'b0, dp_i});
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered image and
// a dark interval at the start of every digit slot.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  seg7_scan_ctrl_if.slave   wr_if,
  output logic              frame_done_o,
  output logic [DIGITS-1:0] sel_o,
  output logic [7:0]        seg_o
);
  localparam int unsigned DW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  scan_state_e                state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [DW-1:0]              digit_q, digit_d;
  logic [DIGITS-1:0][3:0]     act_data_q, act_data_d, shd_data_q, shd_data_d;
  logic [DIGITS-1:0]          act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]          act_blank_q, act_blank_d, shd_blank_q, shd_blank_d;
  logic                       pend_q, pend_d;
  logic                       fd_q, fd_d;
  logic [DIGITS-1:0]          sel_q, sel_d;
  logic [7:0]                 seg_q, seg_d;
  logic [7:0]                 dec_seg;
  logic                       slot_end, boundary;

  seg7_hex_decode u_dec (
    .nibble_i (act_data_q[digit_q]),
    .dp_i     (act_dp_q[digit_q]),
    .seg_o    (dec_seg)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BLANK;
      timer_q     <= '0;
      digit_q     <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      shd_data_q  <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      pend_q      <= 1'b0;
      fd_q        <= 1'b0;
      sel_q       <= '0;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      digit_q     <= digit_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      shd_data_q  <= shd_data_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      pend_q      <= pend_d;
      fd_q        <= fd_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    digit_d     = digit_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    pend_d      = pend_q;
    sel_d       = '0;
    seg_d       = SEG_OFF;

    slot_end = (state_q == ST_ON) && (timer_q == TW'(SCAN_DIV - 1));
    boundary = slot_end && (digit_q == DW'(DIGITS - 1));
    fd_d     = boundary;

    case (state_q)
      ST_BLANK: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(BLANK_CYC - 1)) state_d = ST_ON;
      end
      ST_ON: begin
        if (slot_end) begin
          timer_d = '0;
          state_d = ST_BLANK;
          digit_d = boundary ? '0 : digit_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // A write landing on the frame boundary bypasses the shadow and
    // supersedes whatever was pending.
    if (wr_if.wr_en) begin
      shd_data_d  = wr_if.wr_data;
      shd_dp_d    = wr_if.wr_dp;
      shd_blank_d = wr_if.wr_blank;
      if (boundary) begin
        act_data_d  = wr_if.wr_data;
        act_dp_d    = wr_if.wr_dp;
        act_blank_d = wr_if.wr_blank;
        pend_d      = 1'b0;
      end else begin
        pend_d      = 1'b1;
      end
    end else if (boundary && pend_q) begin
      act_data_d  = shd_data_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
      pend_d      = 1'b0;
    end

    // Digit only changes on entry to BLANK, so digit_q is valid for any ON cycle.
    if (state_d == ST_ON) begin
      sel_d = DIGITS'(1) << digit_q;
      seg_d = act_blank_q[digit_q] ? SEG_OFF : dec_seg;
    end
  end

  assign wr_if.upd_pend = pend_q;
  assign frame_done_o   = fd_q;
  assign sel_o          = sel_q;
  assign seg_o          = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a slot/frame arithmetic model.
module tb_seg7_scan_ctrl;
  localparam int unsigned DIGITS    = 8;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.DIGITS(DIGITS)) wr_if ();
  logic       frame_done;
  logic [7:0] sel;
  logic [7:0] seg;

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_if        (wr_if),
    .frame_done_o (frame_done),
    .sel_o        (sel),
    .seg_o        (seg)
  );

  int checks   = 0;
  int failures = 0;

  // Model: t = cycles since reset release; slot, digit and phase follow from t.
  int unsigned t;
  logic [31:0] m_data, s_data;
  logic [7:0]  m_dp, m_blank, s_dp, s_blank;
  logic        m_pend, m_fd;
  logic [7:0]  hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  task automatic model_reset();
    t = 0; m_data = '0; m_dp = '0; m_blank = '0;
    s_data = '0; s_dp = '0; s_blank = '0; m_pend = 1'b0; m_fd = 1'b0;
  endtask

  function automatic logic [7:0] exp_sel();
    if ((t % SCAN_DIV) < BLANK_CYC) return 8'h00;
    return 8'(1) << ((t / SCAN_DIV) % DIGITS);
  endfunction

  function automatic logic [7:0] exp_seg();
    int unsigned d;
    logic [3:0]  nib;
    if ((t % SCAN_DIV) < BLANK_CYC) return 8'hFF;
    d = (t / SCAN_DIV) % DIGITS;
    if (m_blank[d]) return 8'hFF;
    nib = m_data[4*d +: 4];
    return ~(hex_tab[nib] | {7'b0, m_dp[d]});
  endfunction

  task automatic step();
    logic bnd;
    @(posedge clk);
    if (!rst) begin
      bnd = ((t % FRAME) == FRAME - 1);
      if (wr_if.wr_en) begin
        if (bnd) begin
          m_data = wr_if.wr_data; m_dp = wr_if.wr_dp; m_blank = wr_if.wr_blank; m_pend = 1'b0;
        end else begin
          s_data = wr_if.wr_data; s_dp = wr_if.wr_dp; s_blank = wr_if.wr_blank; m_pend = 1'b1;
        end
      end else if (bnd && m_pend) begin
        m_data = s_data; m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
      end
      m_fd = bnd;
      t++;
    end
    #1;
  endtask

  task automatic write_now(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    wr_if.wr_en = 1'b1; wr_if.wr_data = d; wr_if.wr_dp = dp; wr_if.wr_blank = bl;
    step();
    wr_if.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (sel !== 8'h00) begin failures++; $display("FAIL reset_sel got=%h exp=00", sel); end
    if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=FF", seg); end
    if (wr_if.upd_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", wr_if.upd_pend); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_startup();
    while (t < 10) begin
      step();
      checks += 2;
      if (sel !== exp_sel()) begin failures++; $display("FAIL start_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
      if (seg !== exp_seg()) begin failures++; $display("FAIL start_seg t=%0d got=%h exp=%h", t, seg, exp_seg()); end
      if (t == 2 || t == 10) begin
        checks++;
        if (sel !== (t == 2 ? 8'h01 : 8'h02)) begin failures++; $display("FAIL start_const_sel t=%0d got=%h", t, sel); end
      end
    end
  endtask

  task automatic test_mid_frame_write();
    write_now(32'h76543210, 8'h00, 8'h00);
    checks++;
    if (wr_if.upd_pend !== 1'b1) begin failures++; $display("FAIL mid_pend got=%b exp=1", wr_if.upd_pend); end
    while (t < 2 * FRAME) begin
      step();
      checks += 4;
      if (sel !== exp_sel()) begin failures++; $display("FAIL mid_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
      if (seg !== exp_seg()) begin failures++; $display("FAIL mid_seg t=%0d got=%h exp=%h", t, seg, exp_seg()); end
      if (wr_if.upd_pend !== m_pend) begin failures++; $display("FAIL mid_pend t=%0d got=%b exp=%b", t, wr_if.upd_pend, m_pend); end
      if (frame_done !== m_fd) begin failures++; $display("FAIL mid_fd t=%0d got=%b exp=%b", t, frame_done, m_fd); end
      if (t == FRAME + SCAN_DIV + BLANK_CYC) begin
        checks++;
        if ({sel, seg} !== 16'h029F) begin failures++; $display("FAIL mid_slot1 got=%h%h exp=029F", sel, seg); end
      end
      if (t == FRAME + 7 * SCAN_DIV + BLANK_CYC) begin
        checks++;
        if ({sel, seg} !== 16'h801F) begin failures++; $display("FAIL mid_slot7 got=%h%h exp=801F", sel, seg); end
      end
    end
  endtask

  task automatic test_boundary_write();
    write_now(32'h1111_1111, 8'h00, 8'h00);
    while ((t % FRAME) != FRAME - 1) begin
      step();
      checks += 2;
      if (seg !== exp_seg()) begin failures++; $display("FAIL bnd_pre_seg t=%0d got=%h exp=%h", t, seg, exp_seg()); end
      if (wr_if.upd_pend !== m_pend) begin failures++; $display("FAIL bnd_pre_pend t=%0d got=%b exp=%b", t, wr_if.upd_pend, m_pend); end
    end
    write_now(32'h0000_000A, 8'h00, 8'h00);
    checks += 2;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL bnd_fd got=%b exp=1", frame_done); end
    if (wr_if.upd_pend !== 1'b0) begin failures++; $display("FAIL bnd_pend got=%b exp=0", wr_if.upd_pend); end
    while ((t % FRAME) != BLANK_CYC) step();
    checks += 2;
    if (sel !== 8'h01) begin failures++; $display("FAIL bnd_sel got=%h exp=01", sel); end
    if (seg !== 8'h11) begin failures++; $display("FAIL bnd_seg got=%h exp=11", seg); end
  endtask

  task automatic test_blank_dp();
    int unsigned ph, d;
    logic [7:0]  want;
    write_now(32'h8888_8888, 8'h01, 8'h08);
    while ((t % FRAME) != 0) step();
    repeat (FRAME) begin
      step();
      ph = t % SCAN_DIV;
      d  = (t / SCAN_DIV) % DIGITS;
      want = (ph < BLANK_CYC || d == 3) ? 8'hFF : (d == 0 ? 8'h00 : 8'h01);
      checks += 2;
      if (seg !== want) begin failures++; $display("FAIL bdp_seg t=%0d got=%h exp=%h", t, seg, want); end
      if (sel !== exp_sel()) begin failures++; $display("FAIL bdp_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
    end
  endtask

  task automatic test_random_writes();
    repeat (400) begin
      if ($urandom_range(5) == 0)
        write_now($urandom, 8'($urandom), 8'($urandom_range(255) & 8'h55));
      else
        step();
      checks += 4;
      if (sel !== exp_sel()) begin failures++; $display("FAIL rnd_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
      if (seg !== exp_seg()) begin failures++; $display("FAIL rnd_seg t=%0d got=%h exp=%h", t, seg, exp_seg()); end
      if (wr_if.upd_pend !== m_pend) begin failures++; $display("FAIL rnd_pend t=%0d got=%b exp=%b", t, wr_if.upd_pend, m_pend); end
      if (frame_done !== m_fd) begin failures++; $display("FAIL rnd_fd t=%0d got=%b exp=%b", t, frame_done, m_fd); end
    end
  endtask

  task automatic test_async_reset();
    while ((t % FRAME) != 5 * SCAN_DIV) step();
    write_now($urandom | 32'h1, 8'h00, 8'h00);
    while ((t % FRAME) != 5 * SCAN_DIV + 4) step();
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (sel !== 8'h00) begin failures++; $display("FAIL arst_sel got=%h exp=00", sel); end
    if (seg !== 8'hFF) begin failures++; $display("FAIL arst_seg got=%h exp=FF", seg); end
    if (wr_if.upd_pend !== 1'b0) begin failures++; $display("FAIL arst_pend got=%b exp=0", wr_if.upd_pend); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (FRAME) begin
      step();
      checks += 2;
      if (sel !== exp_sel()) begin failures++; $display("FAIL arst_run_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
      if (seg !== exp_seg()) begin failures++; $display("FAIL arst_run_seg t=%0d got=%h exp=%h", t, seg, exp_seg()); end
      if (t == BLANK_CYC) begin
        checks++;
        if ({sel, seg} !== 16'h0103) begin failures++; $display("FAIL arst_d0 got=%h%h exp=0103", sel, seg); end
      end
    end
  endtask

  task automatic test_frame_timing();
    int last = -1;
    int seen = 0;
    int unsigned t0 = t;
    int want;
    repeat (200) begin
      step();
      checks += 2;
      if ($countones(sel) > 1) begin failures++; $display("FAIL ft_onehot t=%0d got=%h exp=onehot", t, sel); end
      if (sel !== exp_sel()) begin failures++; $display("FAIL ft_sel t=%0d got=%h exp=%h", t, sel, exp_sel()); end
      if (frame_done === 1'b1) begin
        seen++;
        if (last >= 0) begin
          checks++;
          if (int'(t) - last != int'(FRAME)) begin
            failures++; $display("FAIL ft_period t=%0d got=%0d exp=%0d", t, int'(t) - last, FRAME);
          end
        end
        last = int'(t);
      end
    end
    want = int'((t0 + 200) / FRAME) - int'(t0 / FRAME);
    checks++;
    if (seen != want) begin failures++; $display("FAIL ft_count got=%0d exp=%0d", seen, want); end
  endtask

  initial begin
    wr_if.wr_en = 1'b0; wr_if.wr_data = '0; wr_if.wr_dp = '0; wr_if.wr_blank = '0;
    model_reset();
    test_reset();
    test_startup();
    test_mid_frame_write();
    test_boundary_write();
    test_blank_dp();
    test_random_writes();
    test_async_reset();
    test_frame_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
